// File: rtl/sprite_bank.sv
// Multi-sprite overlay: per-sprite shadow/active register sets, a priority hit test
// against the current pixel, and sticky per-sprite collision flags with a CPU read port.
module sprite_bank #(
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W     = 12,
    parameter int SIZE_W      = 8,
    parameter int COLOR_W     = 12,
    parameter int ID_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ID_W+1:0]      wr_addr,
    input  logic [15:0]          wr_data,
    input  logic                 rd_en,
    input  logic [ID_W+1:0]      rd_addr,
    output logic [15:0]          rd_data,
    input  logic                 screenbegin,
    input  logic [COORD_W-1:0]   h_addr,
    input  logic [COORD_W-1:0]   v_addr,
    output logic                 pixel_on,
    output logic [COLOR_W-1:0]   pixel_color,
    output logic [ID_W-1:0]      sprite_id,
    output logic                 collision_irq
);
    localparam int XW = COORD_W + 1;
    localparam logic [ID_W-1:0] GLOBAL_IDX = ID_W'(NUM_SPRITES);

    logic [ID_W-1:0] wr_idx;
    logic [ID_W-1:0] rd_idx;
    logic [1:0]      wr_sel;
    logic [1:0]      rd_sel;

    assign wr_idx = wr_addr[ID_W+1:2];
    assign wr_sel = wr_addr[1:0];
    assign rd_idx = rd_addr[ID_W+1:2];
    assign rd_sel = rd_addr[1:0];

    logic [NUM_SPRITES-1:0] hit;
    logic [COLOR_W-1:0]     act_color [NUM_SPRITES];
    logic [15:0]            sh_rd_word [NUM_SPRITES];

    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : sprite_g
            logic [COORD_W-1:0] x_sh_reg, y_sh_reg, x_act_reg, y_act_reg;
            logic [SIZE_W-1:0]  w_sh_reg, h_sh_reg, w_act_reg, h_act_reg;
            logic [COLOR_W-1:0] color_sh_reg, color_act_reg;
            logic               en_sh_reg, en_act_reg;
            logic               wr_hit;
            logic [XW-1:0]      x_end, y_end;
            logic [15:0]        rd_word;

            assign wr_hit = wr_en && (wr_idx == ID_W'(gi));

            // Active copies take the shadow value as it stood before any same-cycle write.
            always_ff @(posedge clk) begin
                if (rst) begin
                    x_sh_reg      <= '0;
                    y_sh_reg      <= '0;
                    w_sh_reg      <= '0;
                    h_sh_reg      <= '0;
                    color_sh_reg  <= '0;
                    en_sh_reg     <= 1'b0;
                    x_act_reg     <= '0;
                    y_act_reg     <= '0;
                    w_act_reg     <= '0;
                    h_act_reg     <= '0;
                    color_act_reg <= '0;
                    en_act_reg    <= 1'b0;
                end else begin
                    if (wr_hit) begin
                        case (wr_sel)
                            2'd0: x_sh_reg <= wr_data[COORD_W-1:0];
                            2'd1: y_sh_reg <= wr_data[COORD_W-1:0];
                            2'd2: begin
                                w_sh_reg <= wr_data[SIZE_W-1:0];
                                h_sh_reg <= wr_data[8 +: SIZE_W];
                            end
                            default: begin
                                en_sh_reg    <= wr_data[0];
                                color_sh_reg <= wr_data[4 +: COLOR_W];
                            end
                        endcase
                    end
                    if (screenbegin) begin
                        x_act_reg     <= x_sh_reg;
                        y_act_reg     <= y_sh_reg;
                        w_act_reg     <= w_sh_reg;
                        h_act_reg     <= h_sh_reg;
                        color_act_reg <= color_sh_reg;
                        en_act_reg    <= en_sh_reg;
                    end
                end
            end

            // One extra bit on the far edge so sprites near the screen limit clip instead of wrapping.
            assign x_end = {1'b0, x_act_reg} + XW'(w_act_reg);
            assign y_end = {1'b0, y_act_reg} + XW'(h_act_reg);

            assign hit[gi] = en_act_reg
                          && (h_addr >= x_act_reg) && ({1'b0, h_addr} < x_end)
                          && (v_addr >= y_act_reg) && ({1'b0, v_addr} < y_end);

            assign act_color[gi] = color_act_reg;

            always_comb begin
                rd_word = '0;
                case (rd_sel)
                    2'd0:    rd_word = 16'(x_sh_reg);
                    2'd1:    rd_word = 16'(y_sh_reg);
                    2'd2:    rd_word = (16'(h_sh_reg) << 8) | 16'(w_sh_reg);
                    default: rd_word = (16'(color_sh_reg) << 4) | 16'(en_sh_reg);
                endcase
            end

            assign sh_rd_word[gi] = rd_word;
        end
    endgenerate

    // Lowest index wins: scan downward so the last assignment is the lowest hitting sprite.
    logic               win_on;
    logic [COLOR_W-1:0] win_color;
    logic [ID_W-1:0]    win_id;

    always_comb begin
        win_on    = 1'b0;
        win_color = '0;
        win_id    = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_on    = 1'b1;
                win_color = act_color[i];
                win_id    = ID_W'(i);
            end
        end
    end

    logic [NUM_SPRITES-1:0] coll_reg, coll_next, clr_mask, set_mask;
    logic                   multi_hit;

    assign multi_hit = |(hit & (hit - NUM_SPRITES'(1)));
    assign clr_mask  = (wr_en && (wr_idx == GLOBAL_IDX) && (wr_sel == 2'd0))
                     ? wr_data[NUM_SPRITES-1:0] : '0;
    assign set_mask  = multi_hit ? hit : '0;
    // Applying the set after the clear makes a coincident new collision survive the W1C.
    assign coll_next = (coll_reg & ~clr_mask) | set_mask;

    logic [15:0] rd_word_next;

    always_comb begin
        rd_word_next = '0;
        if (rd_idx == GLOBAL_IDX) begin
            case (rd_sel)
                2'd0:    rd_word_next = 16'(coll_reg);
                2'd1:    rd_word_next = 16'(NUM_SPRITES);
                default: rd_word_next = '0;
            endcase
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (rd_idx == ID_W'(i)) begin
                    rd_word_next = sh_rd_word[i];
                end
            end
        end
    end

    logic               pixel_on_reg;
    logic [COLOR_W-1:0] pixel_color_reg;
    logic [ID_W-1:0]    sprite_id_reg;
    logic               irq_reg;
    logic [15:0]        rd_data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_on_reg    <= 1'b0;
            pixel_color_reg <= '0;
            sprite_id_reg   <= '0;
            coll_reg        <= '0;
            irq_reg         <= 1'b0;
            rd_data_reg     <= '0;
        end else begin
            pixel_on_reg    <= win_on;
            pixel_color_reg <= win_color;
            sprite_id_reg   <= win_id;
            coll_reg        <= coll_next;
            irq_reg         <= |coll_next;
            if (rd_en) begin
                rd_data_reg <= rd_word_next;
            end
        end
    end

    assign pixel_on      = pixel_on_reg;
    assign pixel_color   = pixel_color_reg;
    assign sprite_id     = sprite_id_reg;
    assign collision_irq = irq_reg;
    assign rd_data       = rd_data_reg;

endmodule
